// File: rtl/dmem_if.sv
// Load/store request bus between the MEM pipeline stage and the data-memory responder.
// The pipeline side is the master; the responder is the slave.
interface dmem_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        stall_o;
    logic        misalign_o;

    modport master (
        output MemRead_i,
        output MemWrite_i,
        output addr_i,
        output write_data_i,
        input  read_data_o,
        input  stall_o,
        input  misalign_o
    );

    modport slave (
        input  MemRead_i,
        input  MemWrite_i,
        input  addr_i,
        input  write_data_i,
        output read_data_o,
        output stall_o,
        output misalign_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage.
// Each aligned access holds the pipeline for WAIT_CYCLES+1 cycles; misaligned requests are flagged and dropped.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_LOAD_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]  CNT_LOAD     = 4'(CNT_LOAD_INT);
    localparam bit          NO_WAIT      = (WAIT_CYCLES == 0);

    state_t state, state_next;
    logic [3:0] cnt;

    logic              op_write_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       data_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] read_data_q;
    logic        misalign_q;

    logic              req;
    logic              aligned;
    logic              start;
    logic              reject;
    logic [ADDR_W-1:0] req_idx;
    logic              commit;
    logic              commit_write;
    logic [ADDR_W-1:0] commit_idx;
    logic [31:0]       commit_data;
    logic              unused_addr_bits;

    assign req     = bus.MemRead_i | bus.MemWrite_i;
    assign aligned = (bus.addr_i[1:0] == 2'b00);
    assign req_idx = bus.addr_i[ADDR_W+1:2];
    assign start   = (state == IDLE) && req && aligned;
    assign reject  = (state == IDLE) && req && !aligned;

    // Upper address bits are deliberately dropped so addresses wrap modulo the memory size.
    assign unused_addr_bits = ^bus.addr_i[31:ADDR_W+2];

    // With no wait states the access commits straight from IDLE using the live inputs.
    always_comb begin
        commit       = 1'b0;
        commit_write = op_write_q;
        commit_idx   = idx_q;
        commit_data  = data_q;
        if (NO_WAIT && start) begin
            commit       = 1'b1;
            commit_write = bus.MemWrite_i;
            commit_idx   = req_idx;
            commit_data  = bus.write_data_i;
        end else if (state == WAIT && cnt == 4'd0) begin
            commit = 1'b1;
        end
        if (rst) commit = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = NO_WAIT ? DONE : WAIT;
            WAIT: if (cnt == 4'd0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: outputs get a default before any condition so the combinational block never infers a latch.
    always_comb begin
        bus.stall_o = 1'b0;
        if (!rst && (start || state == WAIT)) bus.stall_o = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
        end else if (start) begin
            cnt        <= CNT_LOAD;
            op_write_q <= bus.MemWrite_i;
            idx_q      <= req_idx;
            data_q     <= bus.write_data_i;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && commit_write) mem[commit_idx] <= commit_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= reject;
            if (commit && !commit_write) read_data_q <= mem[commit_idx];
        end
    end

    assign bus.read_data_o = read_data_q;
    assign bus.misalign_o  = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// A transaction table drives the main sequence; reset abort and zero-wait timing are hand-written.
module tb_dmem_responder;

    logic clk;
    logic rst;

    dmem_if bus2 ();
    dmem_if bus0 ();

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;  // read_data_o expected in DONE (or after a reject)
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // sel=1 targets the zero-wait instance, sel=0 the two-wait instance.
    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus0.MemRead_i = rd; bus0.MemWrite_i = wr; bus0.addr_i = a; bus0.write_data_i = d;
        end else begin
            bus2.MemRead_i = rd; bus2.MemWrite_i = wr; bus2.addr_i = a; bus2.write_data_i = d;
        end
    endtask

    function automatic logic get_stall(input bit sel);
        return sel ? bus0.stall_o : bus2.stall_o;
    endfunction

    function automatic logic get_mis(input bit sel);
        return sel ? bus0.misalign_o : bus2.misalign_o;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus0.read_data_o : bus2.read_data_o;
    endfunction

    // Aligned access: stall high for waits+1 cycles, DONE shows exp_rdata with stall low.
    task automatic txn(input bit sel, input int waits, input string name,
                       input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        drive(sel, rd, wr, a, d);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check({name, ".stall_busy"}, 32'(get_stall(sel)), 32'd1);
        end
        @(negedge clk);
        check({name, ".stall_done"}, 32'(get_stall(sel)), 32'd0);
        check({name, ".rdata"}, get_rdata(sel), exp_rdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({name, ".stall_idle"}, 32'(get_stall(sel)), 32'd0);
    endtask

    // Misaligned access: no stall, one-cycle flag in the following cycle, read data untouched.
    task automatic reject_txn(input bit sel, input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        drive(sel, rd, wr, a, d);
        @(negedge clk);
        check({name, ".no_stall"}, 32'(get_stall(sel)), 32'd0);
        check({name, ".mis_early"}, 32'(get_mis(sel)), 32'd0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({name, ".mis_pulse"}, 32'(get_mis(sel)), 32'd1);
        check({name, ".rdata"}, get_rdata(sel), exp_rdata);
        @(negedge clk);
        check({name, ".mis_clear"}, 32'(get_mis(sel)), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"wr_10",      1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{"rd_10",      1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2]  = '{"rd_13_mis",  1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[3]  = '{"wr_0",       1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF};
        vecs[4]  = '{"wr_400_wrap",1'b0, 1'b1, 32'h0000_0400, 32'h0000_0002, 32'hDEAD_BEEF};
        vecs[5]  = '{"rd_0",       1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
        vecs[6]  = '{"both_20",    1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'h0000_0002};
        vecs[7]  = '{"rd_20",      1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0055};
        vecs[8]  = '{"wr_22_mis",  1'b0, 1'b1, 32'h0000_0022, 32'h0000_FFFF, 32'h0000_0055};
        vecs[9]  = '{"wr_30",      1'b0, 1'b1, 32'h0000_0030, 32'h0000_0011, 32'h0000_0055};
        vecs[10] = '{"wr_3fc_top", 1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0000_0055};
        vecs[11] = '{"rd_fffffffc",1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678};
        vecs[12] = '{"rd_20_again",1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0055};

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        // Aligned request present during reset must not stall.
        #2;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        repeat (2) @(negedge clk);
        check("rst.stall", 32'(bus2.stall_o), 32'd0);
        check("rst.mis", 32'(bus2.misalign_o), 32'd0);
        check("rst.rdata", bus2.read_data_o, 32'h0);
        check("rst.rdata0", bus0.read_data_o, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle.stall", 32'(bus2.stall_o), 32'd0);
        check("idle.mis", 32'(bus2.misalign_o), 32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].addr[1:0] != 2'b00)
                reject_txn(1'b0, vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                           vecs[i].wdata, vecs[i].exp_rdata);
            else
                txn(1'b0, 2, vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Reset during WAIT aborts a pending write of 0xAA over 0x11.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_00AA);
        @(negedge clk);
        check("abort.stall_T", 32'(bus2.stall_o), 32'd1);
        @(posedge clk); #1;
        check("abort.stall_wait", 32'(bus2.stall_o), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.stall_rst", 32'(bus2.stall_o), 32'd0);
        check("abort.rdata_rst", bus2.read_data_o, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort.idle_stall", 32'(bus2.stall_o), 32'd0);
        txn(1'b0, 2, "abort.rd_30", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0011);

        // Zero-wait instance: single stall cycle, data valid in the next cycle.
        txn(1'b1, 0, "w0.wr_10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000);
        txn(1'b1, 0, "w0.rd_10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        txn(1'b1, 0, "w0.wr_14", 1'b0, 1'b1, 32'h0000_0014, 32'h0BAD_CAFE, 32'hDEAD_BEEF);
        reject_txn(1'b1, "w0.rd_13_mis", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF);
        txn(1'b1, 0, "w0.rd_14", 1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'h0BAD_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
